// File: rtl/apb_addr_decoder_if.sv
// APB decoder bus bundle: master request signals, fanned-out slave
// responses and the decoded selects/muxed response back to the master.
interface apb_addr_decoder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SLAVE_NUM  = 4
);
   logic [ADDR_WIDTH-1:0]           PADDR;
   logic                            PSEL;
   logic                            PENABLE;
   logic [SLAVE_NUM-1:0]            PSELX;
   logic [SLAVE_NUM*DATA_WIDTH-1:0] PRDATA_S;
   logic [SLAVE_NUM-1:0]            PREADY_S;
   logic [SLAVE_NUM-1:0]            PSLVERR_S;
   logic [DATA_WIDTH-1:0]           PRDATA;
   logic                            PREADY;
   logic                            PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE,
      output PRDATA_S, PREADY_S, PSLVERR_S,
      input  PSELX, PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE,
      input  PRDATA_S, PREADY_S, PSLVERR_S,
      output PSELX, PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_addr_decoder.sv
// APB 1:N slot decoder with latched select and response mux.
// Optional watchdog on stalled slaves: define APB_DEC_TIMEOUT_EN.
module apb_addr_decoder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SLAVE_NUM  = 4,
   parameter int SLOT_BITS  = 12,
   parameter int TIMEOUT    = 16
) (
   input  logic             PCLK,
   input  logic             PRESET,
   apb_addr_decoder_if.slave bus
);
   localparam int IDX_W  = (SLAVE_NUM > 2) ? $clog2(SLAVE_NUM) : 1;
   localparam int HI_LSB = SLOT_BITS + IDX_W;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   if (SLAVE_NUM < 2 || TIMEOUT < 1) begin : g_param_err
      $error("apb_addr_decoder: SLAVE_NUM must be >= 2, TIMEOUT >= 1");
   end

   logic [0:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  hit_q, hit_d;
   logic                  setup;
   logic                  sel_rdy, sel_err;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  tmo;
   logic [SLAVE_NUM-1:0]  pselx;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready, pslverr;

   assign idx_d = bus.PADDR[SLOT_BITS +: IDX_W];
   assign hit_d = ({1'b0, idx_d} < (IDX_W+1)'(SLAVE_NUM))
               && ((bus.PADDR >> HI_LSB) == '0);
   assign setup = (state_q == S_IDLE) && bus.PSEL && !bus.PENABLE;

   // Response mux keyed only by the latched index, never by PADDR.
   always_comb begin
      sel_rdy  = 1'b0;
      sel_err  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_rdy  = bus.PREADY_S[i];
            sel_err  = bus.PSLVERR_S[i];
            sel_data = bus.PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef APB_DEC_TIMEOUT_EN
   localparam int WC_W = $clog2(TIMEOUT + 1);

   logic [WC_W-1:0] wcnt_q, wcnt_d;

   assign tmo = (wcnt_q == WC_W'(TIMEOUT));

   always_comb begin
      wcnt_d = wcnt_q;
      if (setup) begin
         wcnt_d = '0;
      end else if (state_q == S_ACCESS && !sel_rdy && !tmo) begin
         wcnt_d = wcnt_q + 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pselx   = '0;
      prdata  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (setup) begin
               state_d = S_ACCESS;
               if (hit_d) pselx = SLAVE_NUM'(1) << idx_d;
            end
         end
         S_ACCESS: begin
            if (!bus.PSEL) begin
               state_d = S_IDLE;
            end else begin
               if (hit_q) begin
                  pselx = SLAVE_NUM'(1) << idx_q;
                  if (sel_rdy) begin
                     pready  = 1'b1;
                     pslverr = sel_err;
                     prdata  = sel_data;
                  end else if (tmo) begin
                     pready  = 1'b1;
                     pslverr = 1'b1;
                  end
               end else begin
                  pready  = 1'b1;
                  pslverr = 1'b1;
               end
               if (pready) state_d = S_IDLE;
            end
         end
      endcase
   end

   assign bus.PSELX   = PRESET ? '0   : pselx;
   assign bus.PRDATA  = PRESET ? '0   : prdata;
   assign bus.PREADY  = PRESET ? 1'b0 : pready;
   assign bus.PSLVERR = PRESET ? 1'b0 : pslverr;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (setup) begin
            idx_q <= idx_d;
            hit_q <= hit_d;
         end
      end
   end
endmodule

// File: doc/apb_addr_decoder.md
Name: apb_addr_decoder

Overview:
- Parametrised APB decoder that connects one APB master to SLAVE_NUM slaves using address-based slot decoding.
- Latches the selected slave at the setup phase, so later address changes cannot redirect the select.
- Muxes PRDATA, PREADY and PSLVERR back to the master.
- Completes unmapped accesses with an error; an optional watchdog aborts stalled transfers.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- SLAVE_NUM, 4, number of slaves (≥2; non-power-of-two allowed).
- SLOT_BITS, 12, log2 of bytes per slave slot.
- TIMEOUT, 16, maximum wait cycles before forced completion (≥1; used only with the watchdog).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous, active-high reset
- PADDR  in  ADDR_WIDTH  master address
- PSEL  in  1  master select
- PENABLE  in  1  master enable
- PSELX  out  SLAVE_NUM  one-hot slave selects
- PRDATA_S  in  SLAVE_NUM*DATA_WIDTH  slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- PREADY_S  in  SLAVE_NUM  slave ready
- PSLVERR_S  in  SLAVE_NUM  slave error
- PRDATA  out  DATA_WIDTH  read data to master
- PREADY  out  1  ready to master
- PSLVERR  out  1  error to master

Behaviour:
- Clocking and reset:
  - One clock, PCLK.
  - PRESET is synchronous and active-high.
  - While PRESET=1, all outputs are 0.
  - On the next edge with PRESET=1: state←IDLE, idx←0, hit←0, wcnt←0.
- Decode:
  - IDX_W = max(1, clog2(SLAVE_NUM)).
  - idx_d = PADDR[SLOT_BITS +: IDX_W].
  - hit_d = 1 only if idx_d < SLAVE_NUM and every PADDR bit above SLOT_BITS+IDX_W is 0.
- FSM state IDLE (also covers the setup cycle):
  - PSEL=1 and PENABLE=0: setup. PSELX is one-hot(idx_d) if hit_d, else 0. Register idx←idx_d, hit←hit_d, wcnt←0; go to ACCESS.
  - PSEL=1 and PENABLE=1 (no setup seen): protocol violation. Ignored; all outputs 0; stay in IDLE.
  - PRDATA, PREADY and PSLVERR are 0 in IDLE.
- FSM state ACCESS:
  - PSELX = one-hot(registered idx) if hit, else 0. It ignores PADDR for the whole access phase.
  - hit=1: PREADY=PREADY_S[idx]; PRDATA=PRDATA_S slice idx; PSLVERR=PSLVERR_S[idx] gated by PREADY.
  - hit=0: zero-wait error; PREADY=1, PSLVERR=1, PRDATA=0 in the first access cycle.
  - When PREADY=1, go to IDLE.
  - A following setup is decoded in the next cycle, giving back-to-back transfers with no bubble.
  - If PSEL=0 during ACCESS (master abort): outputs 0 that cycle; go to IDLE.
- PRDATA is valid only while PREADY=1 and is 0 otherwise.
- wcnt:
  - Width clog2(TIMEOUT+1).
  - Increments each ACCESS cycle in which the selected PREADY_S=0.
  - Saturates at TIMEOUT.
- No combinational path from PADDR to PREADY, PRDATA or PSLVERR in ACCESS.

Optional Feature:
- Macro: APB_DEC_TIMEOUT_EN.
- Defined:
  - In ACCESS with hit=1 and wcnt==TIMEOUT, the decoder forces PREADY=1, PSLVERR=1, PRDATA=0 that cycle.
  - PSELX stays asserted during this cycle; the FSM then returns to IDLE.
  - Total access length is TIMEOUT+1 cycles.
  - If the slave asserts PREADY_S in that same cycle, the slave response wins (normal PRDATA and PSLVERR).
- Undefined:
  - The decoder waits indefinitely for the slave.
  - wcnt logic is removed and TIMEOUT is unused.

Test Plan (SLAVE_NUM=4, SLOT_BITS=12, TIMEOUT=8):
1. Normal read with wait states. Setup with PADDR=0x2010. Slave 2 holds PREADY low for 2 cycles, then returns 0xDEADBEEF with PSLVERR_S=0.
   - Required: PSELX=4'b0100 in setup and 3 access cycles.
   - Required: PREADY=1 in the 3rd access cycle with PRDATA=0xDEADBEEF, PSLVERR=0.
2. Unmapped addresses, PADDR=0x0001_0000 and PADDR=0x4000 (SLAVE_NUM=3 build).
   - Required: PSELX=0.
   - Required: first access cycle has PREADY=1, PSLVERR=1, PRDATA=0.
3. Timeout, with APB_DEC_TIMEOUT_EN defined. PADDR=0x1000; slave 1 PREADY stuck at 0.
   - Required: PSELX=4'b0010 for 9 access cycles.
   - Required: 9th cycle has PREADY=1, PSLVERR=1, PRDATA=0.
   - Repeat with slave 1 asserting ready in the 9th cycle with PRDATA=0x55. Required: PRDATA=0x55, PSLVERR=0.
4. Address change after setup. Setup at PADDR=0x1000; PADDR changes to 0x3000 during access.
   - Required: PSELX stays 4'b0010 until completion.
5. Back-to-back transfers. Completion to slave 0 is immediately followed by a setup at 0x3004.
   - Required: PSELX=4'b1000 in the next cycle; no idle cycle inserted.
6. Reset and protocol violations.
   - PRESET=1 during the 2nd wait cycle of an access to slave 1. Required: all outputs 0 that cycle; IDLE and wcnt=0 afterwards.
   - PSEL=1 with PENABLE=1 in IDLE. Required: outputs stay 0.
